// File: rtl/psk_symbol_mapper.sv
// rtl/psk_symbol_mapper.sv - serial coded bits to Gray-mapped BPSK/QPSK/8PSK I/Q points with phase rotation
// Optional PSK_MAPPER_AUTO_ROTATE_EN: phase steps come from a transfer counter instead of i_shift_phase_stb.
module psk_symbol_mapper #(
    parameter int IQ_WIDTH            = 10,
    parameter int ROTATE_PERIOD_WIDTH = 24
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [1:0]                     i_mod_type,
    input  logic [2:0]                     i_angle_step,
    input  logic [ROTATE_PERIOD_WIDTH-1:0] i_rotate_period,
    input  logic                           i_shift_phase_stb,
    input  logic                           i_sync,
    output logic                           o_last_phase_stb,
    input  logic                           i_bit,
    input  logic                           i_bit_valid,
    output logic                           o_bit_ready,
    output logic signed [IQ_WIDTH-1:0]     o_data_i,
    output logic signed [IQ_WIDTH-1:0]     o_data_q,
    output logic                           o_valid,
    input  logic                           i_ready
);

    localparam int AMP_INT  = (1 << (IQ_WIDTH - 1)) - 1;
    localparam int DIAG_INT = (AMP_INT * 707) / 1000;

    localparam logic signed [IQ_WIDTH-1:0] P_A  = IQ_WIDTH'(AMP_INT);
    localparam logic signed [IQ_WIDTH-1:0] N_A  = IQ_WIDTH'(-AMP_INT);
    localparam logic signed [IQ_WIDTH-1:0] P_B  = IQ_WIDTH'(DIAG_INT);
    localparam logic signed [IQ_WIDTH-1:0] N_B  = IQ_WIDTH'(-DIAG_INT);
    localparam logic signed [IQ_WIDTH-1:0] ZERO = '0;

    logic [1:0] mod_reg;
    logic [2:0] step_reg;
    logic [2:0] angle_reg;
    logic [2:0] angle_next;
    logic [1:0] bit_cnt;
    logic [1:0] shift_reg;
    logic [2:0] bits_next;
    logic [1:0] bits_needed;
    logic [2:0] map_k;
    logic       last_bit;
    logic       bit_accept;
    logic       pend_valid;
    logic [2:0] pend_k;
    logic       move;
    logic       phase_stb;
    logic signed [IQ_WIDTH-1:0] lut_i;
    logic signed [IQ_WIDTH-1:0] lut_q;

    assign move        = pend_valid & (~o_valid | i_ready);
    assign o_bit_ready = ~i_reset & (~pend_valid | move);
    assign bit_accept  = i_bit_valid & o_bit_ready;
    assign angle_next  = angle_reg + step_reg;
    assign last_bit    = (bit_cnt == (bits_needed - 2'd1));

    // Gray decode of the symbol completed by the incoming bit (earlier bits are MSBs).
    always_comb begin
        bits_next   = {shift_reg, i_bit};
        bits_needed = 2'd1;
        map_k       = 3'd0;
        case (mod_reg)
            2'd1: begin
                bits_needed = 2'd2;
                case (bits_next[1:0])
                    2'b00:   map_k = 3'd1;
                    2'b10:   map_k = 3'd3;
                    2'b11:   map_k = 3'd5;
                    default: map_k = 3'd7;
                endcase
            end
            2'd2: begin
                bits_needed = 2'd3;
                case (bits_next)
                    3'b000:  map_k = 3'd0;
                    3'b001:  map_k = 3'd1;
                    3'b011:  map_k = 3'd2;
                    3'b010:  map_k = 3'd3;
                    3'b110:  map_k = 3'd4;
                    3'b111:  map_k = 3'd5;
                    3'b101:  map_k = 3'd6;
                    default: map_k = 3'd7;
                endcase
            end
            default: map_k = i_bit ? 3'd4 : 3'd0;
        endcase
    end

    always_comb begin
        lut_i = ZERO;
        lut_q = ZERO;
        case (pend_k)
            3'd0: begin lut_i = P_A;  lut_q = ZERO; end
            3'd1: begin lut_i = P_B;  lut_q = P_B;  end
            3'd2: begin lut_i = ZERO; lut_q = P_A;  end
            3'd3: begin lut_i = N_B;  lut_q = P_B;  end
            3'd4: begin lut_i = N_A;  lut_q = ZERO; end
            3'd5: begin lut_i = N_B;  lut_q = N_B;  end
            3'd6: begin lut_i = ZERO; lut_q = N_A;  end
            default: begin lut_i = P_B; lut_q = N_B; end
        endcase
    end

`ifdef PSK_MAPPER_AUTO_ROTATE_EN
    logic [ROTATE_PERIOD_WIDTH-1:0] xfer_cnt;
    logic                           xfer;
    logic                           unused_manual;

    assign xfer          = o_valid & i_ready;
    assign phase_stb     = ~i_sync & xfer & (xfer_cnt == i_rotate_period);
    assign unused_manual = i_shift_phase_stb;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_sync) begin
            xfer_cnt <= '0;
        end else if (xfer) begin
            if (xfer_cnt == i_rotate_period) begin
                xfer_cnt <= '0;
            end else begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_auto;

    assign phase_stb   = i_shift_phase_stb;
    assign unused_auto = &{1'b0, i_sync, i_rotate_period};
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mod_reg          <= i_mod_type;
            step_reg         <= i_angle_step;
            angle_reg        <= 3'd0;
            bit_cnt          <= 2'd0;
            shift_reg        <= 2'd0;
            pend_valid       <= 1'b0;
            pend_k           <= 3'd0;
            o_valid          <= 1'b0;
            o_data_i         <= ZERO;
            o_data_q         <= ZERO;
            o_last_phase_stb <= 1'b0;
        end else begin
            if (bit_accept) begin
                shift_reg <= bits_next[1:0];
                bit_cnt   <= last_bit ? 2'd0 : bit_cnt + 2'd1;
            end
            // A completed symbol refills the pending stage even as it drains.
            if (bit_accept && last_bit) begin
                pend_valid <= 1'b1;
                pend_k     <= map_k + angle_reg;
            end else if (move) begin
                pend_valid <= 1'b0;
            end
            if (move) begin
                o_valid  <= 1'b1;
                o_data_i <= lut_i;
                o_data_q <= lut_q;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (phase_stb) begin
                angle_reg <= angle_next;
            end
            o_last_phase_stb <= phase_stb && (angle_next == 3'd0);
        end
    end

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// tb/tb_psk_symbol_mapper.sv - vector table, corner sequences and randomized model check for psk_symbol_mapper
module tb_psk_symbol_mapper;

    localparam int IQW  = 10;
    localparam int RPW  = 24;
    localparam int AMP  = 511;
    localparam int C8 [8] = '{2, 1, 0, -1, -2, -1, 0, 1};
    localparam int QK [4] = '{1, 7, 3, 5};

    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic [1:0]            i_mod_type = 2'd0;
    logic [2:0]            i_angle_step = 3'd0;
    logic [RPW-1:0]        i_rotate_period = 24'd3;
    logic                  i_shift_phase_stb = 1'b0;
    logic                  i_sync = 1'b0;
    logic                  o_last_phase_stb;
    logic                  i_bit = 1'b0;
    logic                  i_bit_valid = 1'b0;
    logic                  o_bit_ready;
    logic signed [IQW-1:0] o_data_i;
    logic signed [IQW-1:0] o_data_q;
    logic                  o_valid;
    logic                  i_ready = 1'b1;

    psk_symbol_mapper #(.IQ_WIDTH(IQW), .ROTATE_PERIOD_WIDTH(RPW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_mod_type(i_mod_type), .i_angle_step(i_angle_step),
        .i_rotate_period(i_rotate_period), .i_shift_phase_stb(i_shift_phase_stb), .i_sync(i_sync),
        .o_last_phase_stb(o_last_phase_stb), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
        .o_bit_ready(o_bit_ready), .o_data_i(o_data_i), .o_data_q(o_data_q),
        .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int got_i [$];
    int got_q [$];
    int exp_i [$];
    int exp_q [$];

    int m_mod, m_step, m_angle, m_nbits, m_acc, m_cnt;
    bit prev_stall;
    int prev_i, prev_q;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int scale(input int v);
        int diag;
        diag = $rtoi(0.707 * AMP);
        case (v)
            2:       return AMP;
            1:       return diag;
            -1:      return -diag;
            -2:      return -AMP;
            default: return 0;
        endcase
    endfunction

    function automatic int gray_k(input int mod, input int acc);
        if (mod == 0) return acc * 4;
        if (mod == 1) return QK[acc];
        for (int k = 0; k < 8; k++)
            if ((k ^ (k >> 1)) == acc) return k;
        return 0;
    endfunction

    // Reference model and stream checks, evaluated on the falling edge where everything is settled.
    always @(negedge clk) begin
        int k;
        bit s;
        if (i_reset) begin
            m_mod = (i_mod_type == 2'd3) ? 0 : int'(i_mod_type);
            m_step = int'(i_angle_step);
            m_angle = 0; m_nbits = 0; m_acc = 0; m_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(o_valid), 1);
                check("hold_i", int'(o_data_i), prev_i);
                check("hold_q", int'(o_data_q), prev_q);
            end
            if (!o_bit_ready) check("ready_low_cause", int'(o_valid && !i_ready), 1);
            if (i_bit_valid && o_bit_ready) begin
                m_acc = m_acc * 2 + int'(i_bit);
                m_nbits++;
                if (m_nbits == m_mod + 1) begin
                    k = (gray_k(m_mod, m_acc) + m_angle) % 8;
                    exp_i.push_back(scale(C8[k]));
                    exp_q.push_back(scale(C8[(k + 6) % 8]));
                    m_acc = 0;
                    m_nbits = 0;
                end
            end
`ifdef PSK_MAPPER_AUTO_ROTATE_EN
            s = 1'b0;
            if (i_sync) m_cnt = 0;
            else if (o_valid && i_ready) begin
                if (m_cnt == int'(i_rotate_period)) begin s = 1'b1; m_cnt = 0; end
                else m_cnt++;
            end
`else
            s = i_shift_phase_stb;
`endif
            if (s) m_angle = (m_angle + m_step) % 8;
            if (o_valid && i_ready) begin
                got_i.push_back(int'(o_data_i));
                got_q.push_back(int'(o_data_q));
            end
            prev_stall = o_valid && !i_ready;
            prev_i = int'(o_data_i);
            prev_q = int'(o_data_q);
        end
    end

    task automatic do_reset(input int mod, input int step);
        i_reset = 1'b1;
        i_mod_type = 2'(mod);
        i_angle_step = 3'(step);
        i_bit_valid = 1'b0;
        i_shift_phase_stb = 1'b0;
        i_sync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_i", int'(o_data_i), 0);
        check("rst_q", int'(o_data_q), 0);
        check("rst_last_stb", int'(o_last_phase_stb), 0);
        check("rst_bit_ready", int'(o_bit_ready), 0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        got_i.delete(); got_q.delete(); exp_i.delete(); exp_q.delete();
        @(negedge clk);
        check("post_rst_bit_ready", int'(o_bit_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input int b);
        bit ok;
        ok = 1'b0;
        i_bit = b[0];
        i_bit_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_bit_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("bit_accept_timeout", 0, 1);
        @(posedge clk); #1;
        i_bit_valid = 1'b0;
    endtask

    task automatic wait_symbols(input int n, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (got_i.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #2;
        end
        if (!ok) check({name, "_timeout"}, got_i.size(), n);
    endtask

    task automatic strobe_once();
        i_shift_phase_stb = 1'b1;
        @(posedge clk); #1;
        i_shift_phase_stb = 1'b0;
    endtask

    typedef struct {
        int mod; int step; int nstb; int nb;
        int b0; int b1; int b2;
        int ei; int eq;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vec_t v;
        int nb [3];

        vecs[0] = '{0, 0, 0, 1, 1, 0, 0, -511, 0};
        vecs[1] = '{1, 0, 0, 2, 0, 1, 0, 361, -361};
        vecs[2] = '{1, 0, 0, 2, 1, 0, 0, -361, 361};
        vecs[3] = '{2, 0, 0, 3, 0, 1, 1, 0, 511};
        vecs[4] = '{2, 0, 0, 3, 1, 0, 0, 361, -361};
        vecs[5] = '{1, 2, 1, 2, 0, 0, 0, -361, 361};
        vecs[6] = '{3, 0, 0, 1, 0, 0, 0, 511, 0};
        vecs[7] = '{2, 5, 1, 3, 0, 0, 0, -361, -361};

        i_rotate_period = 24'hFFFFFF;

        // BPSK back-to-back bits with the two-cycle latency.
        do_reset(0, 0);
        i_ready = 1'b1;
        i_bit = 1'b0; i_bit_valid = 1'b1;
        @(negedge clk); check("lat_t0_valid", int'(o_valid), 0);
        @(posedge clk); #1; i_bit = 1'b1;
        @(negedge clk); check("lat_t1_valid", int'(o_valid), 0);
        @(posedge clk); #1; i_bit_valid = 1'b0;
        @(negedge clk);
        check("lat_t2_valid", int'(o_valid), 1);
        check("bpsk0_i", int'(o_data_i), 511);
        check("bpsk0_q", int'(o_data_q), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bpsk1_valid", int'(o_valid), 1);
        check("bpsk1_i", int'(o_data_i), -511);
        check("bpsk1_q", int'(o_data_q), 0);
        @(posedge clk); #1;

        for (int r = 0; r < 8; r++) begin
            v = vecs[r];
`ifdef PSK_MAPPER_AUTO_ROTATE_EN
            if (v.nstb != 0) continue;
`endif
            do_reset(v.mod, v.step);
            for (int s = 0; s < v.nstb; s++) strobe_once();
            nb[0] = v.b0; nb[1] = v.b1; nb[2] = v.b2;
            for (int b = 0; b < v.nb; b++) send_bit(nb[b]);
            wait_symbols(1, $sformatf("vec%0d", r));
            if (got_i.size() >= 1) begin
                check($sformatf("vec%0d_i", r), got_i[0], v.ei);
                check($sformatf("vec%0d_q", r), got_q[0], v.eq);
            end
        end

`ifndef PSK_MAPPER_AUTO_ROTATE_EN
        // Four step-2 strobes wrap the phase; the pulse follows only the fourth.
        do_reset(1, 2);
        for (int j = 1; j <= 4; j++) begin
            strobe_once();
            @(negedge clk);
            check($sformatf("last_stb_%0d", j), int'(o_last_phase_stb), int'(j == 4));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("last_stb_pulse_end", int'(o_last_phase_stb), 0);
        @(posedge clk); #1;
`endif

        // A partial 8PSK symbol is discarded by reset.
        do_reset(2, 0);
        send_bit(1); send_bit(1);
        do_reset(2, 0);
        send_bit(0); send_bit(0); send_bit(1);
        repeat (6) @(posedge clk);
        #1;
        check("partial_count", got_i.size(), 1);
        if (got_i.size() >= 1) begin
            check("partial_i", got_i[0], 361);
            check("partial_q", got_q[0], 361);
        end

        // Randomized streams with backpressure against the reference model.
        for (int mod = 0; mod < 3; mod++) begin
            i_rotate_period = 24'd3;
            do_reset(mod, int'($urandom_range(0, 7)));
            for (int c = 0; c < 400; c++) begin
                i_ready = ($urandom_range(0, 9) >= 3);
                i_bit_valid = ($urandom_range(0, 3) != 0);
                i_bit = 1'($urandom);
                i_shift_phase_stb = ($urandom_range(0, 9) == 0);
                i_sync = ($urandom_range(0, 29) == 0);
                @(posedge clk); #1;
            end
            i_bit_valid = 1'b0; i_shift_phase_stb = 1'b0; i_sync = 1'b0; i_ready = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check($sformatf("rand%0d_count", mod), got_i.size(), exp_i.size());
            for (int n = 0; n < got_i.size() && n < exp_i.size(); n++) begin
                check($sformatf("rand%0d_i[%0d]", mod, n), got_i[n], exp_i[n]);
                check($sformatf("rand%0d_q[%0d]", mod, n), got_q[n], exp_q[n]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
